// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 pipeline flow-control slice.
// Stage indices run from the operand input registers towards the P register.
package dsp_pkg;

    localparam int DSP_NSTAGE = 4;

    localparam int STG_IN  = 0;
    localparam int STG_PRE = 1;
    localparam int STG_M   = 2;
    localparam int STG_P   = 3;

    localparam logic [DSP_NSTAGE-1:0] DSP_RESET_SEL = 4'b1111;

endpackage

// File: rtl/dsp_pipe_slot.sv
// One pipeline stage: a valid bit plus the forward-valid / backward-ready equations.
// A bypassed stage (sel = 0) is a wire in both directions and holds no item.
module dsp_pipe_slot (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic sel,
    input  logic vin,
    input  logic rout,
    output logic vout,
    output logic rin,
    output logic ce
);

    logic v_reg;
    logic v_next;

    assign vout = sel ? v_reg : vin;
    // An empty registered stage accepts even when downstream is stalled, so bubbles collapse.
    assign rin  = sel ? (~v_reg | rout) : rout;
    assign ce   = sel & rin & vin & ~flush;

    always_comb begin
        v_next = v_reg;
        if (!sel) begin
            v_next = 1'b0;
        end else if (rin) begin
            v_next = vin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= 1'b0;
        end else if (flush) begin
            v_reg <= 1'b0;
        end else begin
            v_reg <= v_next;
        end
    end

endmodule

// File: rtl/dsp_pipe_ctrl.sv
// Flow-control sequencer for the DSP48A1 pipeline: per-stage clock enables, valid tracking,
// valid/ready backpressure, occupancy counting and guarded register/bypass reconfiguration.
module dsp_pipe_ctrl
    import dsp_pkg::*;
#(
    parameter int                NSTAGE    = DSP_NSTAGE,
    parameter logic [NSTAGE-1:0] RESET_SEL = NSTAGE'(DSP_RESET_SEL),
    parameter int                CW        = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              cfg_we,
    input  logic [NSTAGE-1:0] cfg_wdata,
    output logic [NSTAGE-1:0] cfg_sel,
    output logic              cfg_err,
    output logic [NSTAGE-1:0] stage_ce,
    output logic [CW-1:0]     occupancy
);

    logic [NSTAGE-1:0] cfg_sel_reg;
    logic [NSTAGE-1:0] cfg_sel_next;
    logic              cfg_err_reg;
    logic              cfg_err_next;
    logic [CW-1:0]     occ_reg;
    logic [CW-1:0]     occ_next;
    logic              in_xfer;
    logic              out_xfer;
    logic              cfg_ok;

    // Each slot lives in its own generate scope so the valid and ready chains are
    // separate nets per stage rather than bits of one self-referencing vector.
    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : gen_slot
            logic vin_s;
            logic rout_s;
            logic vout_s;
            logic rin_s;

            if (gi == 0) begin : g_head
                assign vin_s = in_valid;
            end else begin : g_body
                assign vin_s = gen_slot[gi-1].vout_s;
            end

            if (gi == NSTAGE - 1) begin : g_tail
                assign rout_s = out_ready;
            end else begin : g_link
                assign rout_s = gen_slot[gi+1].rin_s;
            end

            dsp_pipe_slot u_slot (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .sel   (cfg_sel_reg[gi]),
                .vin   (vin_s),
                .rout  (rout_s),
                .vout  (vout_s),
                .rin   (rin_s),
                .ce    (stage_ce[gi])
            );
        end
    endgenerate

    assign in_ready  = gen_slot[0].rin_s & ~flush;
    assign out_valid = gen_slot[NSTAGE-1].vout_s & ~flush;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        occ_next = occ_reg;
        if (in_xfer && !out_xfer) begin
            occ_next = occ_reg + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_next = occ_reg - CW'(1);
        end
    end

    // Reconfigure only when provably empty; otherwise in-flight valid bits would be reinterpreted.
    assign cfg_ok = cfg_we & (occ_reg == '0) & ~in_xfer & ~flush;

    always_comb begin
        cfg_sel_next = cfg_sel_reg;
        cfg_err_next = 1'b0;
        if (cfg_ok) begin
            cfg_sel_next = cfg_wdata;
        end else if (cfg_we) begin
            cfg_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_sel_reg <= RESET_SEL;
            cfg_err_reg <= 1'b0;
            occ_reg     <= '0;
        end else begin
            cfg_sel_reg <= cfg_sel_next;
            cfg_err_reg <= cfg_err_next;
            occ_reg     <= flush ? '0 : occ_next;
        end
    end

    assign cfg_sel   = cfg_sel_reg;
    assign cfg_err   = cfg_err_reg;
    assign occupancy = occ_reg;

endmodule
